// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetch-buffer entry: the instruction together with the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so every PC stays word-aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(32'd3);
    endfunction

endpackage

// File: rtl/riscv_fetch_buffer.sv
// In-order fetch buffer: DEPTH entries of {pc, instr}, synchronous push/pop,
// single-cycle flush, head outputs forced to zero while empty.
// The caller never pushes into a full buffer without popping, and never
// pops an empty one.
module riscv_fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   head_valid_o,
    output fetch_entry_t           head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];

    // Pointer and occupancy next-state; flush overrides push and pop.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally on overflow.
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (!push_i && pop_i) count_d = count_q - 1'b1;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the count gates the head, so stale entries are never visible.
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, buffers
// fetched {pc, instr} pairs and hands them to decode over valid/ready.
// Priority: reset > redirect > halt > normal fetch.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_dout,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic                   halted
);

    localparam int               CNT_W         = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BUF_DEPTH_CNT = CNT_W'(BUF_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             pop, push;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     wr_entry, head;

    // A pop is a completed handshake even in a redirect cycle; a push needs
    // fetch enabled and room, where a simultaneous pop frees a full slot.
    assign pop      = out_valid & out_ready;
    assign push     = !halted_q & !halt & !redirect_valid &
                      ((buf_count < BUF_DEPTH_CNT) | pop);
    assign wr_entry = '{pc: pc_q, instr: imem_dout};

    // PC and halt-flag next state: redirect wins over sequential fetch.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q | halt;
        if (redirect_valid) pc_d = word_align(redirect_pc);
        else if (push)      pc_d = pc_q + PC_INCR;
    end

    // PC and sticky halt registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    riscv_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk          (clk),
        .rst_ni       (reset),
        .push_i       (push),
        .push_data_i  (wr_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (buf_count),
        .head_valid_o (out_valid),
        .head_o       (head)
    );

    assign imem_addr = pc_q;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = halted_q;

endmodule
